// File: rtl/ahf_input_cond.sv
// Two-flop synchronizer plus per-bit debounce for 4 switches and 4 pushbuttons, with press/release pulses and sticky press flags.
// Latency: a held raw change appears DB_LIMIT+2 edges after reaching the pins; all outputs registered, no backpressure.
module ahf_input_cond #(
   parameter int DB_LIMIT = 4,
   parameter int CNT_W    = 8
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [3:0] SW_raw,
   input  logic [3:0] PB_raw,
   input  logic [3:0] PB_clr,
   output logic [3:0] SW_out,
   output logic [3:0] PB_out,
   output logic [3:0] PB_press,
   output logic [3:0] PB_rel,
   output logic [3:0] PB_pend
);

   localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(DB_LIMIT - 1);

   // Bits [3:0] are switches, [7:4] are pushbuttons.
   logic [7:0]       s1;
   logic [7:0]       s2;
   logic [7:0]       lvl;
   logic [7:0]       diff;
   logic [7:0]       accept;
   logic [CNT_W-1:0] cnt [8];
   logic [3:0]       pb_set;

   always_comb begin
      diff   = s2 ^ lvl;
      accept = '0;
      for (int i = 0; i < 8; i++) begin
         accept[i] = diff[i] && (cnt[i] == LIM_M1);
      end
      pb_set = accept[7:4] & s2[7:4];
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         s1       <= '0;
         s2       <= '0;
         lvl      <= '0;
         PB_press <= '0;
         PB_rel   <= '0;
         PB_pend  <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1 <= {PB_raw, SW_raw};
         s2 <= s1;
         for (int i = 0; i < 8; i++) begin
            if (!diff[i] || accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
         // Accepting a differing bit means flipping it to the synchronized level.
         lvl      <= lvl ^ accept;
         PB_press <= pb_set;
         PB_rel   <= accept[7:4] & ~s2[7:4];
         // Set wins over a coincident clear.
         PB_pend  <= (PB_pend & ~PB_clr) | pb_set;
      end
   end

   assign SW_out = lvl[3:0];
   assign PB_out = lvl[7:4];

endmodule

// File: tb/tb_ahf_input_cond.sv
// Directed bench for ahf_input_cond at default DB_LIMIT=4: reset, press/release, glitch reject, switch bus, pend clear, mid-count reset.
module tb_ahf_input_cond;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [3:0] SW_raw;
   logic [3:0] PB_raw;
   logic [3:0] PB_clr;
   logic [3:0] SW_out;
   logic [3:0] PB_out;
   logic [3:0] PB_press;
   logic [3:0] PB_rel;
   logic [3:0] PB_pend;

   int checks = 0;
   int errors = 0;

   ahf_input_cond dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .SW_raw   (SW_raw),
      .PB_raw   (PB_raw),
      .PB_clr   (PB_clr),
      .SW_out   (SW_out),
      .PB_out   (PB_out),
      .PB_press (PB_press),
      .PB_rel   (PB_rel),
      .PB_pend  (PB_pend)
   );

   always #5 Clock = ~Clock;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with every input high.
      Reset = 1'b1; SW_raw = 4'hF; PB_raw = 4'hF; PB_clr = 4'h0;
      tick(1);
      check("rst_sw_out",   SW_out,   4'h0);
      check("rst_pb_out",   PB_out,   4'h0);
      check("rst_pb_press", PB_press, 4'h0);
      check("rst_pb_rel",   PB_rel,   4'h0);
      check("rst_pb_pend",  PB_pend,  4'h0);
      Reset = 1'b0; SW_raw = 4'h0; PB_raw = 4'h0;
      tick(4);
      check("idle_pb_out",  PB_out,   4'h0);

      // PB0 press: sampled into s1 at edge k, accepted at edge k+5.
      PB_raw = 4'b0001;
      tick(5);
      check("pb0_k4_out",   PB_out,   4'b0000);
      tick(1);
      check("pb0_k5_out",   PB_out,   4'b0001);
      check("pb0_k5_press", PB_press, 4'b0001);
      check("pb0_k5_pend",  PB_pend,  4'b0001);
      tick(1);
      check("pb0_k6_press", PB_press, 4'b0000);
      check("pb0_k6_pend",  PB_pend,  4'b0001);
      check("pb0_k6_out",   PB_out,   4'b0001);

      // PB0 release: rel pulse, pend stays sticky.
      PB_raw = 4'b0000;
      tick(5);
      check("rel0_k4_out",  PB_out,   4'b0001);
      tick(1);
      check("rel0_k5_out",  PB_out,   4'b0000);
      check("rel0_k5_rel",  PB_rel,   4'b0001);
      check("rel0_k5_pend", PB_pend,  4'b0001);
      tick(1);
      check("rel0_k6_rel",  PB_rel,   4'b0000);

      // Clear alone drops pend.
      PB_clr = 4'b0001;
      tick(1);
      PB_clr = 4'b0000;
      check("clr0_pend",    PB_pend,  4'b0000);

      // Press again with clear coinciding with the set edge: set wins.
      PB_raw = 4'b0001;
      tick(5);
      PB_clr = 4'b0001;
      tick(1);
      PB_clr = 4'b0000;
      check("setclr_press", PB_press, 4'b0001);
      check("setclr_pend",  PB_pend,  4'b0001);
      tick(2);
      PB_clr = 4'b0001;
      tick(1);
      PB_clr = 4'b0000;
      check("clr0b_pend",   PB_pend,  4'b0000);
      check("clr0b_out",    PB_out,   4'b0001);

      // PB1 glitch of 3 edges: never accepted.
      PB_raw = 4'b0011;
      tick(3);
      PB_raw = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("glitch1_out",   PB_out,   4'b0001);
         check("glitch1_press", PB_press, 4'b0000);
         check("glitch1_pend",  PB_pend,  4'b0000);
      end

      // Switch bus 0101 then 1010, both nibbles flip on the same edge.
      SW_raw = 4'b0101;
      tick(6);
      check("sw_0101",      SW_out,   4'b0101);
      SW_raw = 4'b1010;
      tick(5);
      check("sw_k4",        SW_out,   4'b0101);
      tick(1);
      check("sw_k5",        SW_out,   4'b1010);

      // PB2 held high; reset after two counted edges discards the count.
      PB_raw = 4'b0100;
      tick(4);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      check("mid_rst_pb",   PB_out,   4'b0000);
      check("mid_rst_sw",   SW_out,   4'b0000);
      tick(5);
      check("post_r5_pb",   PB_out,   4'b0000);
      check("post_r5_sw",   SW_out,   4'b0000);
      tick(1);
      check("post_r6_pb",   PB_out,   4'b0100);
      check("post_r6_press",PB_press, 4'b0100);
      check("post_r6_pend", PB_pend,  4'b0100);
      check("post_r6_sw",   SW_out,   4'b1010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahf_input_cond.md
AHF_INPUT_COND -- requirements
Module: ahf_input_cond

Interface
REQ-001 The block SHALL sit directly upstream of the CPU: its SW_out/PB_out drive the CPU SW_in/PB_in ports.
REQ-002 Parameter DB_LIMIT, default 4: number of consecutive clock edges a synchronized input must differ from its accepted level before the change is accepted; legal range 1..2^CNT_W.
REQ-003 Parameter CNT_W, default 8: debounce counter width.
REQ-004 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 SW_raw  in  4  raw slide-switch inputs, asynchronous to Clock.
REQ-007 PB_raw  in  4  raw pushbutton inputs, asynchronous to Clock, 1 = pressed.
REQ-008 PB_clr  in  4  per-bit clear of PB_pend.
REQ-009 SW_out  out  4  debounced switch levels.
REQ-010 PB_out  out  4  debounced pushbutton levels.
REQ-011 PB_press  out  4  one-cycle pulse per bit on a debounced 0->1 transition.
REQ-012 PB_rel  out  4  one-cycle pulse per bit on a debounced 1->0 transition.
REQ-013 PB_pend  out  4  sticky per-bit press flag.

Function
REQ-014 Each of the 8 raw bits SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-015 Each bit SHALL have an independent CNT_W-bit counter and an accepted-level register.
REQ-016 On an edge where s2 equals the accepted level, the counter SHALL be cleared to 0.
REQ-017 On an edge where s2 differs and counter < DB_LIMIT-1, the counter SHALL increment by 1.
REQ-018 On an edge where s2 differs and counter == DB_LIMIT-1, the accepted level SHALL load s2 and the counter SHALL clear.
REQ-019 Latency: a raw change first sampled into s1 at edge k and held SHALL appear on SW_out/PB_out after edge k+1+DB_LIMIT (k+5 at default).
REQ-020 A synchronized pulse lasting fewer than DB_LIMIT consecutive edges SHALL produce no output change, and the counter SHALL return to 0.
REQ-021 With DB_LIMIT = 1, the accepted level SHALL follow s2 with one edge of delay.
REQ-022 Counters SHALL never wrap; the maximum value held is DB_LIMIT-1.
REQ-023 PB_press[i] SHALL be registered and high exactly in the cycle in which PB_out[i] first reads 1 after a 0->1 acceptance; it SHALL be low otherwise.
REQ-024 PB_rel[i] SHALL be registered and high exactly in the cycle in which PB_out[i] first reads 0 after a 1->0 acceptance; it SHALL be low otherwise.
REQ-025 PB_pend[i] SHALL be set at the edge that raises PB_press[i] and SHALL be cleared at an edge with PB_clr[i]=1.
REQ-026 If a set and PB_clr[i] coincide on the same edge, the set SHALL win and PB_pend[i] SHALL stay 1.
REQ-027 Bits SHALL be fully independent; simultaneous changes on several bits SHALL be accepted on the same edge.
REQ-028 SW bits SHALL have no pulse or pending logic.

Reset
REQ-029 On an edge with Reset=1, all synchronizer flops, counters, accepted levels, and the SW_out, PB_out, PB_press, PB_rel and PB_pend outputs SHALL become 0.
REQ-030 Reset asserted mid-count SHALL discard the partial count; counting SHALL restart from 0 after Reset deasserts.
REQ-031 After reset, an input held at 1 SHALL be accepted exactly DB_LIMIT edges after s2 first reads 1.

Verification
REQ-032 Reset=1 for one edge with all inputs at 1 -> all outputs 0 at the following cycle.
REQ-033 PB_raw[0] 0->1, held, DB_LIMIT=4 -> PB_out[0]=1 after edge k+5; PB_press[0]=1 for that single cycle only; PB_pend[0]=1 and remains 1.
REQ-034 PB_raw[1] high for 3 edges then low -> PB_out[1], PB_press[1] and PB_pend[1] stay 0 throughout.
REQ-035 SW_raw 0101->1010, held -> SW_out changes 0101->1010 in one cycle, after edge k+5.
REQ-036 PB_clr[0] on the same edge as a PB_press[0] set -> PB_pend[0]=1; PB_clr[0] alone on a later edge -> PB_pend[0]=0 next cycle.
REQ-037 PB_raw[2] held high, Reset pulsed after 2 counted edges -> PB_out[2] stays 0; PB_out[2] is accepted DB_LIMIT edges after the first post-reset edge where s2=1.
